hazard_stall_ctrl: RTL and testbench

//  Central pipeline sequencer. Drives the IF/ID register controls (stall, flush/condition_met),
//  the PC enable, the ID/EX bubble and the EX freeze. Covers load-use hazards, taken-branch

---
 rtl/hazard_stall_ctrl_pkg.sv | 12 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer:
// FSM state encoding and the zero-register constant.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with async active-high clear.
// Ports: clk, clr, inc (count enable), count (holds at all-ones).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline sequencer: load-use, branch squash, fetch wait, MUL/DIV stall.
// Ports: clk, clr (async reset), ID/EX hazard inputs -> pc/IF-ID/ID-EX/EX controls, stall_cycles.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             md_start,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_stall,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY);

  state_e              state, state_nxt;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic                load_use;

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= ST_RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    pc_en       = 1'b1;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_stall    = 1'b0;
    if (clr) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (md_start) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            ex_stall    = 1'b1;
            md_cnt_nxt  = MD_CNT_W'(MD_LATENCY - 1);
            state_nxt   = ST_MD_WAIT;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          pc_en       = 1'b0;
          if_id_stall = 1'b1;
          ex_stall    = 1'b1;
          md_cnt_nxt  = md_cnt - 1'b1;
          if (md_cnt == MD_CNT_W'(1)) begin
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (!pc_en),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed checks of hazard_stall_ctrl against a behavioural model.
// Small counter width so saturation is reachable.
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 4;
  localparam int CW     = 4;
  localparam int SAT    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rs = 0, id_uses_rt = 0;
  logic          ex_mem_read = 0, ex_branch_taken = 0;
  logic          md_start = 0, imem_ready = 1;
  logic          pc_en, if_id_stall, if_id_flush;
  logic          id_ex_flush, ex_stall;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  int rem = 0;
  int mcnt = 0;

  hazard_stall_ctrl #(
    .MD_LATENCY(MD_LAT),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .clr            (clr),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .md_start       (md_start),
    .imem_ready     (imem_ready),
    .pc_en          (pc_en),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_stall       (ex_stall),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining MUL/DIV stall cycles plus a plain saturating count.
  always @(negedge clk) begin
    bit lu, e_pc, e_ifs, e_iff, e_idf, e_exs;
    int nrem;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((id_uses_rs && id_rs == ex_rt) ||
          (id_uses_rt && id_rt == ex_rt));
    e_pc = 1; e_ifs = 0; e_iff = 0; e_idf = 0; e_exs = 0;
    nrem = rem;
    if (clr) begin
      e_pc = 0; e_iff = 1; e_idf = 1;
    end else if (rem > 0) begin
      e_pc = 0; e_ifs = 1; e_exs = 1; nrem = rem - 1;
    end else if (ex_branch_taken) begin
      e_iff = 1; e_idf = 1;
    end else if (md_start) begin
      e_pc = 0; e_ifs = 1; e_exs = 1; nrem = MD_LAT - 1;
    end else if (lu) begin
      e_pc = 0; e_ifs = 1; e_idf = 1;
    end else if (!imem_ready) begin
      e_pc = 0; e_iff = 1;
    end
    chk("pc_en", int'(pc_en), int'(e_pc));
    chk("if_id_stall", int'(if_id_stall), int'(e_ifs));
    chk("if_id_flush", int'(if_id_flush), int'(e_iff));
    chk("id_ex_flush", int'(id_ex_flush), int'(e_idf));
    chk("ex_stall", int'(ex_stall), int'(e_exs));
    chk("stall_cycles", int'(stall_cycles), clr ? 0 : mcnt);
    if (clr) begin
      rem = 0;
      mcnt = 0;
    end else begin
      rem = nrem;
      if (!e_pc && mcnt < SAT) mcnt++;
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = 0; ex_branch_taken = 0;
    md_start = 0; imem_ready = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] r, input logic use_rs);
    ex_mem_read = 1; ex_rt = r; id_rs = 5; id_uses_rs = use_rs;
  endtask

  task automatic do_reset();
    cyc(); clr = 1; idle();
    cyc(); cyc(); clr = 0;
  endtask

  initial begin
    int n_stall, n_exs, bad;
    idle();
    cyc(); cyc(); clr = 0;
    #1;
    chk("reset_cnt", int'(stall_cycles), 0);
    chk("reset_pc_en", int'(pc_en), 1);

    // Load-use on rs
    cyc(); set_lu(5, 1);
    #1;
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_if_id_stall", int'(if_id_stall), 1);
    chk("lu_id_ex_flush", int'(id_ex_flush), 1);
    cyc(); idle();
    #1;
    chk("lu_after_pc_en", int'(pc_en), 1);
    chk("lu_after_cnt", int'(stall_cycles), 1);

    // No hazard via r0 or unused rs
    cyc(); set_lu(0, 1); id_rs = 0;
    #1; chk("r0_pc_en", int'(pc_en), 1);
    cyc(); idle(); set_lu(5, 0);
    #1; chk("nouse_pc_en", int'(pc_en), 1);

    // MUL/DIV: exactly MD_LAT stall cycles; load-use during wait is ignored
    n_stall = 0; n_exs = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(); idle();
      if (i == 0) md_start = 1;
      if (i == 1 || i == 2) set_lu(5, 1);
      #1;
      if (!pc_en) n_stall++;
      if (ex_stall) n_exs++;
    end
    chk("md_stall_cycles", n_stall, MD_LAT);
    chk("md_ex_stall_cycles", n_exs, MD_LAT);
    chk("md_cnt_total", int'(stall_cycles), 1 + MD_LAT);

    // Branch dominates load-use and md_start
    cyc(); set_lu(5, 1); md_start = 1; ex_branch_taken = 1;
    #1;
    chk("br_if_id_flush", int'(if_id_flush), 1);
    chk("br_id_ex_flush", int'(id_ex_flush), 1);
    chk("br_pc_en", int'(pc_en), 1);
    chk("br_ex_stall", int'(ex_stall), 0);
    cyc(); idle();
    #1; chk("br_still_run", int'(pc_en), 1);

    // Async clear while md_cnt==2
    cyc(); md_start = 1;
    cyc(); idle();
    cyc();
    @(negedge clk); #1; clr = 1; #1;
    chk("clr_pc_en", int'(pc_en), 0);
    chk("clr_if_id_flush", int'(if_id_flush), 1);
    chk("clr_id_ex_flush", int'(id_ex_flush), 1);
    chk("clr_ex_stall", int'(ex_stall), 0);
    chk("clr_cnt", int'(stall_cycles), 0);
    cyc(); cyc(); clr = 0;
    #1;
    chk("postclr_pc_en", int'(pc_en), 1);
    chk("postclr_ex_stall", int'(ex_stall), 0);
    chk("postclr_cnt", int'(stall_cycles), 0);

    // Fetch wait saturates the counter
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); idle(); imem_ready = 0;
      #1;
      if (!if_id_flush) bad++;
    end
    chk("imem_flush_held", bad, 0);
    cyc(); idle();
    #1; chk("sat_cnt", int'(stall_cycles), SAT);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      md_start = ($urandom_range(0, 9) == 0);
      imem_ready = ($urandom_range(0, 5) != 0);
      clr = ($urandom_range(0, 59) == 0);
    end
    cyc(); idle(); clr = 0;
    cyc(); cyc();
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
